// File: rtl/operand_fetch_pkg.sv
// operand_fetch_pkg
//   Shared defaults and types for the operand fetch / issue stage.
//   Contents:
//     DEF_NREG, DEF_DW, DEF_AW : default register count, data width, address width
//     STALL_SAT                : saturation value of the hazard-stall counter
//     state_e                  : output-slot state {EMPTY, FULL}
package operand_fetch_pkg;

    localparam int DEF_NREG = 16;
    localparam int DEF_DW   = 16;
    localparam int DEF_AW   = 4;

    localparam logic [15:0] STALL_SAT = 16'hFFFF;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard
//   Per-register busy (pending write) vector with combinational hazard lookup.
//   Ports:
//     clk, rst                      : clock, synchronous active-high reset
//     set_en / set_addr             : mark a register pending (instruction issued)
//     clr_en / clr_addr             : writeback completed for a register
//     flush_clr_en / flush_clr_addr : flushed instruction releases its destination
//     rs_addr, rt_addr, dst_addr    : lookup addresses
//     rs_busy, rt_busy, dst_busy    : busy bit of each lookup address
//     busy                          : full busy vector
module reg_scoreboard
    import operand_fetch_pkg::*;
#(
    parameter int NREG = DEF_NREG,
    parameter int AW   = DEF_AW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            set_en,
    input  logic [AW-1:0]   set_addr,
    input  logic            clr_en,
    input  logic [AW-1:0]   clr_addr,
    input  logic            flush_clr_en,
    input  logic [AW-1:0]   flush_clr_addr,
    input  logic [AW-1:0]   rs_addr,
    input  logic [AW-1:0]   rt_addr,
    input  logic [AW-1:0]   dst_addr,
    output logic            rs_busy,
    output logic            rt_busy,
    output logic            dst_busy,
    output logic [NREG-1:0] busy
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        busy_d = busy_q;
        if (clr_en) begin
            busy_d[clr_addr] = 1'b0;
        end
        if (flush_clr_en) begin
            busy_d[flush_clr_addr] = 1'b0;
        end
        // Set is applied last so a new issue wins over a same-cycle clear.
        if (set_en) begin
            busy_d[set_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy     = busy_q;
    assign rs_busy  = busy_q[rs_addr];
    assign rt_busy  = busy_q[rt_addr];
    assign dst_busy = busy_q[dst_addr];

endmodule

// File: rtl/operand_fetch.sv
// operand_fetch
//   Register-read and issue stage. Holds the architectural register file and
//   the busy scoreboard, stalls decoded instructions on RAW/WAW hazards and
//   presents operands to execute through a one-entry output slot.
//   Optional feature: define OPERAND_FETCH_FWD_EN to forward same-cycle
//   writeback data into the operands (and to resolve busy sources with it).
//   Ports:
//     clk, rst                          : clock, synchronous active-high reset
//     in_valid/in_ready                 : decoded instruction handshake
//     in_rs, in_rt, in_use_rs, in_use_rt: source addresses and use flags
//     in_wr_en, in_dst                  : destination write flag and address
//     out_valid/out_ready               : operand handshake to execute
//     out_a, out_b, out_dst, out_wr_en  : issued operands and destination
//     wb_en, wb_addr, wb_data           : writeback port (sole register writer)
//     flush                             : kills the held output instruction
//     busy                              : scoreboard vector
//     stall_cnt                         : saturating hazard-stall cycle count
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int NREG = DEF_NREG,
    parameter int DW   = DEF_DW,
    parameter int AW   = DEF_AW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [AW-1:0]   in_rs,
    input  logic [AW-1:0]   in_rt,
    input  logic            in_use_rs,
    input  logic            in_use_rt,
    input  logic            in_wr_en,
    input  logic [AW-1:0]   in_dst,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_a,
    output logic [DW-1:0]   out_b,
    output logic [AW-1:0]   out_dst,
    output logic            out_wr_en,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_addr,
    input  logic [DW-1:0]   wb_data,
    input  logic            flush,
    output logic [NREG-1:0] busy,
    output logic [15:0]     stall_cnt
);

    state_e          state_q, state_d;
    logic [DW-1:0]   out_a_q, out_a_d;
    logic [DW-1:0]   out_b_q, out_b_d;
    logic [AW-1:0]   out_dst_q, out_dst_d;
    logic            out_wr_en_q, out_wr_en_d;
    logic [15:0]     stall_cnt_q, stall_cnt_d;
    logic [DW-1:0]   regs_q [NREG];
    logic [DW-1:0]   regs_d [NREG];

    logic            rs_busy, rt_busy, dst_busy;
    logic            rs_fwd, rt_fwd;
    logic            hazard;
    logic            accept;
    logic            flush_clr_en;
    logic [DW-1:0]   rs_val, rt_val;

    reg_scoreboard #(
        .NREG (NREG),
        .AW   (AW)
    ) u_scoreboard (
        .clk            (clk),
        .rst            (rst),
        .set_en         (accept && in_wr_en),
        .set_addr       (in_dst),
        .clr_en         (wb_en),
        .clr_addr       (wb_addr),
        .flush_clr_en   (flush_clr_en),
        .flush_clr_addr (out_dst_q),
        .rs_addr        (in_rs),
        .rt_addr        (in_rt),
        .dst_addr       (in_dst),
        .rs_busy        (rs_busy),
        .rt_busy        (rt_busy),
        .dst_busy       (dst_busy),
        .busy           (busy)
    );

`ifdef OPERAND_FETCH_FWD_EN
    // A source matching the same-cycle writeback takes the new data and is
    // no longer waiting on that register.
    assign rs_fwd = wb_en && (wb_addr == in_rs);
    assign rt_fwd = wb_en && (wb_addr == in_rt);
`else
    assign rs_fwd = 1'b0;
    assign rt_fwd = 1'b0;
`endif

    assign rs_val = rs_fwd ? wb_data : regs_q[in_rs];
    assign rt_val = rt_fwd ? wb_data : regs_q[in_rt];

    // WAW uses the registered busy bit only: a same-cycle writeback to in_dst
    // must not let a second writer slip in ahead of the cleared scoreboard.
    assign hazard = (in_use_rs && rs_busy && !rs_fwd)
                 || (in_use_rt && rt_busy && !rt_fwd)
                 || (in_wr_en && dst_busy);

    assign in_ready     = !flush && ((state_q == EMPTY) || out_ready) && !hazard;
    assign accept       = in_valid && in_ready;
    assign flush_clr_en = flush && (state_q == FULL) && out_wr_en_q;

    always_comb begin
        state_d     = state_q;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        out_dst_d   = out_dst_q;
        out_wr_en_d = out_wr_en_q;
        stall_cnt_d = stall_cnt_q;
        regs_d      = regs_q;

        if (flush) begin
            state_d = EMPTY;
        end else if (accept) begin
            state_d     = FULL;
            out_a_d     = in_use_rs ? rs_val : '0;
            out_b_d     = in_use_rt ? rt_val : '0;
            out_dst_d   = in_dst;
            out_wr_en_d = in_wr_en;
        end else if ((state_q == FULL) && out_ready) begin
            state_d = EMPTY;
        end

        if (wb_en) begin
            regs_d[wb_addr] = wb_data;
        end

        if (in_valid && !flush && hazard && (stall_cnt_q != STALL_SAT)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_dst_q   <= '0;
            out_wr_en_q <= 1'b0;
            stall_cnt_q <= '0;
            // NOTE: the register file is architecturally zero after reset, so
            // it is cleared here like any other flop rather than left as RAM.
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            out_dst_q   <= out_dst_d;
            out_wr_en_q <= out_wr_en_d;
            stall_cnt_q <= stall_cnt_d;
            regs_q      <= regs_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
    assign out_dst   = out_dst_q;
    assign out_wr_en = out_wr_en_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Register-read and issue stage at the read end of the writeback interface. Holds the 16 x 16-bit architectural register file and a per-register busy (scoreboard) bit. Accepts decoded instructions, stalls until their source and destination registers are available, then presents operand values to execute. Writeback is the only writer of the register file and clears busy bits; this block sets them at issue.

## Interface
- `NREG`, 16, number of architectural registers
- `DW`, 16, register data width
- `AW`, 4, register address width ($clog2(NREG))
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  decoded instruction present
- `in_ready`  out  1  instruction accepted this cycle when high together with `in_valid`
- `in_rs`, `in_rt`  in  AW  source register addresses
- `in_use_rs`, `in_use_rt`  in  1  source actually read
- `in_wr_en`  in  1  instruction writes a register
- `in_dst`  in  AW  destination register, already resolved by decode (rd or rs)
- `out_valid`  out  1  operands valid for execute
- `out_ready`  in  1  execute consumes the operands
- `out_a`, `out_b`  out  DW  operand values for rs and rt
- `out_dst`  out  AW  destination register
- `out_wr_en`  out  1  destination write flag
- `wb_en`  in  1  writeback write strobe
- `wb_addr`  in  AW  writeback register address
- `wb_data`  in  DW  writeback data
- `flush`  in  1  jump flush; kills the held output instruction
- `busy`  out  NREG  scoreboard vector, bit i set means register i is pending
- `stall_cnt`  out  16  count of hazard-stall cycles, saturating

## Operation
- Two states: EMPTY (`out_valid`=0) and FULL (`out_valid`=1).
- A source is a hazard when its use bit is set, its busy bit is set, and it is not resolved by same-cycle forwarding (see Configuration).
- WAW hazard: `in_wr_en` set and `busy[in_dst]` set. Writeback to `in_dst` in the same cycle does not clear this hazard.
- `in_ready` = !`flush` & (EMPTY | `out_ready`) & no hazard.
- On accept: `out_a`/`out_b` capture the register values (0 when the use bit is clear), `out_dst` and `out_wr_en` are loaded, the state becomes FULL, and `busy[in_dst]` is set when `in_wr_en` is set.
- FULL with `out_ready` and no accept: the state returns to EMPTY.
- Writeback: when `wb_en` is set, `regs[wb_addr]` is written with `wb_data` and `busy[wb_addr]` is cleared. A write to a non-busy register still updates the data.
- Simultaneous set and clear on the same busy bit: set wins.
- Flush: `out_valid` drops the next cycle, no accept happens that cycle, and when FULL with `out_wr_en` set, `busy[out_dst]` is cleared. Busy bits of instructions already past execute are untouched.
- `stall_cnt` increments on each cycle with `in_valid` set, `flush` clear, and a hazard present. It holds at 16'hFFFF.
- `rst` mid-operation discards the held instruction, zeroes the register file, and clears all busy bits.

## Timing
- Reset values: `out_valid`=0, `out_a`=`out_b`=0, `out_dst`=0, `out_wr_en`=0, `busy`=0, `stall_cnt`=0, all registers 0.
- `in_ready` is combinational from inputs and state.
- Latency is 1 cycle from accept to `out_valid`.
- Full throughput: one instruction per cycle while `out_ready` stays high and no hazards occur.
- A writeback at edge N makes the new value readable for an accept at edge N+1 without forwarding, and at edge N with forwarding.
- Outputs stay stable while `out_valid` & !`out_ready`.

## Configuration
- `OPERAND_FETCH_FWD_EN` defined:
  - A busy source whose address equals `wb_addr` with `wb_en` set counts as ready.
  - Its operand captures `wb_data`.
  - A non-busy source matching `wb_addr` also captures `wb_data`.
- Not defined:
  - A busy source stalls until the cycle after writeback.
  - A non-busy source matching `wb_addr` captures the pre-write value.

## Structure
- Package `operand_fetch_pkg` holds:
  - `NREG`, `DW`, `AW` defaults
  - the state typedef `{EMPTY, FULL}`
  - the saturation constant `16'hFFFF`
- Sub-module `reg_scoreboard` holds:
  - the busy vector with set, clear and flush-clear ports
  - set-wins priority
  - the combinational hazard lookup for rs, rt and dst

## Test plan
- After reset, issue rs=1, rt=2, dst=3 with `out_ready`=1 -> `out_valid` next cycle, `out_a`=0, `out_b`=0, `busy`=16'h0008.
- Issue dst=3, then an instruction using rs=3; assert `wb_en`, `wb_addr`=3, `wb_data`=16'h00AB two cycles later -> the second instruction is accepted in the writeback cycle with `out_a`=16'h00AB when FWD is defined, or one cycle later otherwise. `stall_cnt` is 2 or 3 respectively.
- Issue dst=5 twice back-to-back -> the second waits until writeback to r5 clears busy (WAW), then `busy[5]` is set again.
- Hold `out_ready`=0 with FULL -> `in_ready`=0 and outputs stay stable for 4 cycles; release -> the next instruction issues.
- Assert `flush` with FULL and dst=7 -> `out_valid`=0 next cycle, `busy[7]`=0, and no accept in the flush cycle.
- Force 70000 hazard cycles -> `stall_cnt` is 16'hFFFF. Assert `rst` -> `stall_cnt`=0, `busy`=0, `out_valid`=0.
